// File: rtl/skid_pipeline.sv
// Chain of full-throughput skid-buffer stages on a valid/ready/data stream.
// Every stage registers both the forward (valid/data) and backward (ready) paths.
module skid_pipeline #(
  parameter int          DATA_BUS_W = 32,
  parameter int          NB_STAGES  = 2,
  parameter int unsigned LEVEL_W    = (NB_STAGES == 0) ? 1 : $clog2(2 * NB_STAGES + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_BUS_W-1:0] i_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_BUS_W-1:0] o_data,
  output logic [LEVEL_W-1:0]    level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  generate
    if (NB_STAGES == 0) begin : g_wire
      assign i_ready = o_ready;
      assign o_valid = i_valid;
      assign o_data  = i_data;
      assign level   = '0;
    end else begin : g_chain
      logic [NB_STAGES:0]  vld;
      logic [NB_STAGES:0]  rdy;
      logic [DATA_BUS_W-1:0] dat [0:NB_STAGES];
      logic                accept_en;
      logic [LEVEL_W-1:0]  level_q;
      logic                in_hs;
      logic                out_hs;

      assign vld[0]         = i_valid;
      assign dat[0]         = i_data;
      assign rdy[NB_STAGES] = o_ready;
      assign i_ready        = rdy[0];
      assign o_valid        = vld[NB_STAGES];
      assign o_data         = dat[NB_STAGES];
      assign level          = level_q;

      assign in_hs  = vld[0] & rdy[0];
      assign out_hs = vld[NB_STAGES] & rdy[NB_STAGES];

      // Holds i_ready low through reset and for the cycle after any clear.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  accept_en <= 1'b0;
        else if (srst) accept_en <= 1'b0;
        else           accept_en <= 1'b1;
      end

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          level_q <= '0;
        end else if (srst) begin
          level_q <= '0;
        end else begin
          case ({in_hs, out_hs})
            2'b10:   level_q <= level_q + LEVEL_W'(1);
            2'b01:   level_q <= level_q - LEVEL_W'(1);
            default: level_q <= level_q;
          endcase
        end
      end

      for (genvar k = 0; k < NB_STAGES; k++) begin : g_stage
        stage_state_e          state;
        logic [DATA_BUS_W-1:0] m_q;
        logic [DATA_BUS_W-1:0] s_q;
        logic                  st_in_hs;
        logic                  st_out_hs;

        if (k == 0) begin : g_head
          assign rdy[k] = (state != FULL) & accept_en & ~srst;
        end else begin : g_body
          assign rdy[k] = (state != FULL);
        end

        assign vld[k+1]  = (state != EMPTY);
        assign dat[k+1]  = m_q;
        assign st_in_hs  = vld[k] & rdy[k];
        assign st_out_hs = vld[k+1] & rdy[k+1];

        always_ff @(posedge aclk or negedge aresetn) begin
          if (!aresetn) begin
            state <= EMPTY;
            m_q   <= '0;
            s_q   <= '0;
          end else if (srst) begin
            state <= EMPTY;
            m_q   <= '0;
            s_q   <= '0;
          end else begin
            case (state)
              EMPTY: begin
                if (st_in_hs) begin
                  m_q   <= dat[k];
                  state <= BUSY;
                end
              end
              BUSY: begin
                if (st_in_hs && st_out_hs) begin
                  m_q <= dat[k];
                end else if (st_in_hs) begin
                  s_q   <= dat[k];
                  state <= FULL;
                end else if (st_out_hs) begin
                  state <= EMPTY;
                end
              end
              FULL: begin
                if (st_out_hs) begin
                  m_q   <= s_q;
                  state <= BUSY;
                end
              end
              default: state <= EMPTY;
            endcase
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_skid_pipeline.sv
// Scoreboard bench for skid_pipeline at NB_STAGES = 2, 4 and 0.
module tb_skid_pipeline;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic srst = 1'b0;

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // NB_STAGES = 2
  logic        a_i_valid = 1'b0, a_i_ready, a_o_valid, a_o_ready = 1'b0;
  logic [31:0] a_i_data = '0, a_o_data;
  logic [2:0]  a_level;
  // NB_STAGES = 4
  logic        b_i_valid = 1'b0, b_i_ready, b_o_valid, b_o_ready = 1'b0;
  logic [31:0] b_i_data = '0, b_o_data;
  logic [3:0]  b_level;
  // NB_STAGES = 0
  logic        c_i_valid = 1'b0, c_i_ready, c_o_valid, c_o_ready = 1'b0;
  logic [31:0] c_i_data = '0, c_o_data;
  logic [0:0]  c_level;

  skid_pipeline #(.DATA_BUS_W(32), .NB_STAGES(2)) u_dut_a (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_valid(a_i_valid), .i_ready(a_i_ready), .i_data(a_i_data),
    .o_valid(a_o_valid), .o_ready(a_o_ready), .o_data(a_o_data), .level(a_level));

  skid_pipeline #(.DATA_BUS_W(32), .NB_STAGES(4)) u_dut_b (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_valid(b_i_valid), .i_ready(b_i_ready), .i_data(b_i_data),
    .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data), .level(b_level));

  skid_pipeline #(.DATA_BUS_W(32), .NB_STAGES(0)) u_dut_c (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_valid(c_i_valid), .i_ready(c_i_ready), .i_data(c_i_data),
    .o_valid(c_o_valid), .o_ready(c_o_ready), .o_data(c_o_data), .level(c_level));

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic        a_hold = 1'b0, b_hold = 1'b0;
  logic [31:0] a_prev = '0, b_prev = '0;

  // Inputs change at posedge+1, so the negedge view is exactly what the next edge samples.
  always @(negedge aclk) begin
    if (aresetn) begin
      check("a_level", 64'(a_level), 64'(q_a.size()));
      if (a_hold && a_o_valid) check("a_stable", 64'(a_o_data), 64'(a_prev));
      a_hold = a_o_valid && !a_o_ready;
      a_prev = a_o_data;
      if (a_o_valid && a_o_ready) begin
        if (q_a.size() == 0) check("a_extra_beat", 64'(a_o_data), 64'hDEAD);
        else check("a_data", 64'(a_o_data), 64'(q_a.pop_front()));
      end
      if (a_i_valid && a_i_ready) q_a.push_back(a_i_data);

      check("b_level", 64'(b_level), 64'(q_b.size()));
      check("b_level_max", 64'(b_level <= 4'd8), 64'd1);
      if (b_hold && b_o_valid) check("b_stable", 64'(b_o_data), 64'(b_prev));
      b_hold = b_o_valid && !b_o_ready;
      b_prev = b_o_data;
      if (b_o_valid && b_o_ready) begin
        if (q_b.size() == 0) check("b_extra_beat", 64'(b_o_data), 64'hDEAD);
        else check("b_data", 64'(b_o_data), 64'(q_b.pop_front()));
      end
      if (b_i_valid && b_i_ready) q_b.push_back(b_i_data);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int n;
    int acc;
    int cyc;
    int first;
    int last;
    int cnt;

    // Reset state
    repeat (3) tick();
    check("rst_a_i_ready", 64'(a_i_ready), 64'd0);
    check("rst_a_o_valid", 64'(a_o_valid), 64'd0);
    check("rst_a_level", 64'(a_level), 64'd0);
    check("rst_a_o_data", 64'(a_o_data), 64'd0);
    check("rst_b_i_ready", 64'(b_i_ready), 64'd0);
    aresetn = 1'b1;
    tick();
    check("rel_a_i_ready", 64'(a_i_ready), 64'd1);
    check("rel_b_i_ready", 64'(b_i_ready), 64'd1);

    // Single beat latency, NB_STAGES=2
    a_o_ready = 1'b1;
    a_i_valid = 1'b1;
    a_i_data  = 32'hA5;
    check("t1_i_ready_c0", 64'(a_i_ready), 64'd1);
    tick();
    a_i_valid = 1'b0;
    check("t1_o_valid_c1", 64'(a_o_valid), 64'd0);
    check("t1_level_c1", 64'(a_level), 64'd1);
    tick();
    check("t1_o_valid_c2", 64'(a_o_valid), 64'd1);
    check("t1_o_data_c2", 64'(a_o_data), 64'hA5);
    check("t1_level_c2", 64'(a_level), 64'd1);
    tick();
    check("t1_o_valid_c3", 64'(a_o_valid), 64'd0);
    check("t1_level_c3", 64'(a_level), 64'd0);

    // Fill to capacity with o_ready low, then release
    a_o_ready = 1'b0;
    a_i_valid = 1'b1;
    n = 1;
    acc = 0;
    a_i_data = 32'(n);
    for (int i = 0; i < 8; i++) begin
      if (a_i_ready) begin
        acc++;
        n++;
      end
      tick();
      a_i_data = 32'(n);
    end
    check("t2_accepted", 64'(acc), 64'd4);
    check("t2_i_ready_full", 64'(a_i_ready), 64'd0);
    check("t2_level_full", 64'(a_level), 64'd4);
    a_o_ready = 1'b1;
    cyc = 0;
    while (n <= 12 && cyc < 100) begin
      if (a_i_ready) n++;
      tick();
      a_i_data = 32'(n);
      cyc++;
    end
    check("t2_stream_timeout", 64'(n > 12), 64'd1);
    a_i_valid = 1'b0;
    cyc = 0;
    while (q_a.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("t2_drained", 64'(q_a.size()), 64'd0);

    // srst with 3 beats in flight
    a_o_ready = 1'b0;
    a_i_valid = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < 3 && cyc < 20) begin
      a_i_data = 32'h30 + 32'(acc);
      if (a_i_ready) acc++;
      tick();
      cyc++;
    end
    a_i_valid = 1'b0;
    check("t3_level_pre", 64'(a_level), 64'd3);
    srst = 1'b1;
    #1;
    check("t3_i_ready_srst", 64'(a_i_ready), 64'd0);
    tick();
    srst = 1'b0;
    q_a.delete();
    check("t3_o_valid_post", 64'(a_o_valid), 64'd0);
    check("t3_level_post", 64'(a_level), 64'd0);
    tick();
    a_i_valid = 1'b1;
    a_i_data  = 32'h55;
    a_o_ready = 1'b1;
    cyc = 0;
    while (!a_i_ready && cyc < 10) begin
      tick();
      cyc++;
    end
    tick();
    a_i_valid = 1'b0;
    cyc = 0;
    while (!a_o_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("t3_first_out_valid", 64'(a_o_valid), 64'd1);
    check("t3_first_out_data", 64'(a_o_data), 64'h55);
    tick();

    // Full throughput, NB_STAGES=4
    b_o_ready = 1'b1;
    first = -1;
    last = -1;
    cnt = 0;
    for (int t = 0; t < 112; t++) begin
      b_i_valid = (t < 100);
      b_i_data  = 32'(t);
      tick();
      if (b_o_valid) begin
        if (first < 0) first = t + 1;
        last = t + 1;
        cnt++;
      end
    end
    check("t4_first_cycle", 64'(first), 64'd4);
    check("t4_beats", 64'(cnt), 64'd100);
    check("t4_last_cycle", 64'(last), 64'd103);

    // Combinational passthrough, NB_STAGES=0
    for (int i = 0; i < 40; i++) begin
      c_i_valid = 1'($urandom_range(0, 1));
      c_o_ready = 1'($urandom_range(0, 1));
      c_i_data  = $urandom;
      #1;
      check("t5_mirror", {c_o_valid, c_i_ready, c_o_data, c_level},
            {c_i_valid, c_o_ready, c_i_data, 1'b0});
      tick();
    end

    // Random valid/ready soak, NB_STAGES=4
    acc = 0;
    cyc = 0;
    b_i_data = $urandom;
    while (acc < 10000 && cyc < 80000) begin
      b_i_valid = 1'($urandom_range(0, 3) != 0);
      b_o_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      if (b_i_valid && b_i_ready) acc++;
      tick();
      if (b_i_valid && q_b.size() > 0) b_i_data = $urandom;
      cyc++;
    end
    check("t6_beats", 64'(acc), 64'd10000);
    b_i_valid = 1'b0;
    b_o_ready = 1'b1;
    cyc = 0;
    while (q_b.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("t6_drained", 64'(q_b.size()), 64'd0);
    check("t6_level_end", 64'(b_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
